// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a first-word-fall-through
// byte FIFO. It reports framing errors and overruns as one-cycle pulses.
// Optional build macro RX_MAJORITY_VOTE_EN: each start, data and stop decision
// becomes a 2-of-3 vote over the mid-1/mid/mid+1 samples. The decision is taken
// one cycle later.
module uart_rx_fifo #(
    parameter int CLK_RATE   = 100_000_000,
    parameter int BAUD_RATE  = 3_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       RX_I,
    input  logic       READ_I,
    output logic [7:0] DATA_REC_O,
    output logic       RX_EMPTY_O,
    output logic       RX_FULL_O,
    output logic       FRAME_ERR_O,
    output logic       OVERRUN_O
);

    localparam int CPB  = CLK_RATE / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB < 4) ? 2 : $clog2(CPB);
    localparam int AW   = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
`ifdef RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif
    // Decision points inside a bit period. The start decision comes at half a
    // bit. After the counter restarts there, the next decision falls one full
    // bit later, which is again mid-bit.
    localparam logic [CW-1:0] START_DEC = CW'(HALF - 1 + MV);
    localparam logic [CW-1:0] BIT_DEC   = CW'(CPB - 1);

    if (CPB < 4) begin : g_bad_baud
        $error("uart_rx_fifo: CLK_RATE/BAUD_RATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        st_idle, st_start, st_data, st_stop, st_wait_idle
    } state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          bit_val;
    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [AW:0]   wr_q, rd_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          empty, full, do_read, do_push;

    // Two-flop synchroniser for the asynchronous line. It idles high.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], RX_I};
    end
    assign rx_s = sync_q[1];

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;
    // Keeps the two previous rx_s values. At a decision point they are the
    // samples taken at mid-1 and mid.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) hist_q <= 2'b11;
        else         hist_q <= {hist_q[0], rx_s};
    end
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // Receiver FSM: next state, counters, shift register and push/error strobes.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            st_idle: begin
                baud_d = '0;
                if (!rx_s) state_d = st_start;
            end
            st_start: begin
                if (baud_q == START_DEC) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = bit_val ? st_idle : st_data;  // high again: glitch
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            st_data: begin
                if (baud_q == BIT_DEC) begin
                    baud_d         = '0;
                    shift_d[bit_q] = bit_val;
                    if (bit_q == 3'd7) state_d = st_stop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            st_stop: begin
                if (baud_q == BIT_DEC) begin
                    baud_d = '0;
                    if (bit_val) begin
                        push    = 1'b1;
                        state_d = st_idle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = st_wait_idle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            st_wait_idle: begin
                if (rx_s) state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

    // FIFO status. The pointers carry one extra wrap bit, so equal low bits
    // with a differing MSB means full.
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_read   = READ_I & ~empty;
    assign do_push   = push & (~full | do_read);
    assign overrun_d = push & full & ~READ_I;

    // Receiver and FIFO state registers, plus the registered error pulses.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q     <= st_idle;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_read) rd_q <= rd_q + 1'b1;
        end
    end

    // Byte storage. It has no reset, so it can map onto RAM.
    always_ff @(posedge CLK_I) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= shift_q;
    end

    assign DATA_REC_O  = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    assign RX_EMPTY_O  = empty;
    assign RX_FULL_O   = full;
    assign FRAME_ERR_O = frame_err_q;
    assign OVERRUN_O   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 48 MHz / 3 Mbaud (16 clocks per bit).
module tb_uart_rx_fifo;
    localparam int CLK_RATE  = 48_000_000;
    localparam int BAUD_RATE = 3_000_000;
    localparam int CPB       = 16;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif
    // Ticks into the stop bit at which the push cycle starts.
    // The stop sample lands 153 cycles after the line edge. The two-flop
    // synchroniser is already included in that count.
    localparam int PUSH_TICK = 10 + MV;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rd    = 1'b0;
    logic [7:0] data;
    logic       empty, full, ferr, ovr;

    uart_rx_fifo #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(8)) dut (
        .CLK_I(clk), .RST_NI(rst_n), .RX_I(rx), .READ_I(rd),
        .DATA_REC_O(data), .RX_EMPTY_O(empty), .RX_FULL_O(full),
        .FRAME_ERR_O(ferr), .OVERRUN_O(ovr)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and the cycle at which RX_EMPTY_O last dropped.
    int   ferr_cnt   = 0;
    int   ovr_cnt    = 0;
    int   fall_cyc   = -1000;
    logic prev_empty = 1'b1;
    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
        if (ovr)  ovr_cnt++;
        if (prev_empty && !empty) fall_cyc = cyc;
        prev_empty = empty;
    end

    int tests = 0;
    int fails = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame. read_tick > 0 raises READ_I for one cycle at that tick
    // of the stop bit.
    task automatic send(input logic [7:0] b, input logic stop, input int read_tick);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop;
        for (int k = 1; k <= CPB; k++) begin
            tick();
            rd = (k == read_tick);
        end
        rd = 1'b0;
    endtask

    task automatic pop(input string name, input logic [7:0] exp);
        check({name, "_nonempty"}, {31'd0, empty}, 32'd0);
        check({name, "_data"}, {24'd0, data}, {24'd0, exp});
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   snap_f;
        int   snap_o;

        vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h33, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h44, 1'b1, 1'b1, 1'b0};

        // Power-on reset.
        repeat (3) tick();
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full},  32'd0);
        check("rst_data",  {24'd0, data},  32'd0);
        check("rst_ferr",  {31'd0, ferr},  32'd0);
        check("rst_ovr",   {31'd0, ovr},   32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Table: single frames, each read back (or not pushed).
        for (int v = 0; v < 6; v++) begin
            snap_f = ferr_cnt;
            send(vecs[v].tx, vecs[v].stop, 0);
            if (!vecs[v].stop) begin
                repeat (40) tick();
                rx = 1'b1;
                repeat (2 * CPB) tick();
            end
            tick();
            $display("[TB] vec %0d tx=0x%02h stop=%0b", v, vecs[v].tx, vecs[v].stop);
            check($sformatf("v%0d_ferr", v), ferr_cnt - snap_f, {31'd0, vecs[v].exp_ferr});
            check($sformatf("v%0d_empty", v), {31'd0, empty}, {31'd0, ~vecs[v].exp_push});
            if (vecs[v].exp_push) begin
                check_range($sformatf("v%0d_latency", v), fall_cyc - start_cyc, 150, 155 + MV);
                pop($sformatf("v%0d", v), vecs[v].tx);
                check($sformatf("v%0d_empty_after", v), {31'd0, empty}, 32'd1);
            end
        end

        // Back-to-back frames, no reads in between.
        send(8'hB1, 1'b1, 0);
        send(8'hB1, 1'b1, 0);
        send(8'h07, 1'b1, 0);
        tick();
        $display("[TB] b2b B1 B1 07");
        check("b2b_full", {31'd0, full}, 32'd0);
        pop("b2b0", 8'hB1);
        pop("b2b1", 8'hB1);
        pop("b2b2", 8'h07);
        check("b2b_empty", {31'd0, empty}, 32'd1);

        // Nine frames into a depth-8 FIFO.
        snap_o = ovr_cnt;
        for (int i = 0; i < 8; i++) send(8'(i), 1'b1, 0);
        tick();
        check("ovf_full8", {31'd0, full}, 32'd1);
        check("ovf_noovr8", ovr_cnt - snap_o, 32'd0);
        send(8'h08, 1'b1, 0);
        tick();
        $display("[TB] overflow 00..08");
        check("ovf_ovr_pulse", ovr_cnt - snap_o, 32'd1);
        check("ovf_full9", {31'd0, full}, 32'd1);
        for (int i = 0; i < 8; i++) pop($sformatf("ovf%0d", i), 8'(i));
        check("ovf_empty", {31'd0, empty}, 32'd1);

        // Full FIFO, read coincides with the push of 0xAA.
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1, 0);
        tick();
        check("sim_full", {31'd0, full}, 32'd1);
        snap_o = ovr_cnt;
        send(8'hAA, 1'b1, PUSH_TICK);
        tick();
        $display("[TB] simultaneous push/read 0xAA");
        check("sim_noovr", ovr_cnt - snap_o, 32'd0);
        check("sim_still_full", {31'd0, full}, 32'd1);
        for (int i = 1; i < 8; i++) pop($sformatf("sim%0d", i), 8'h10 + 8'(i));
        pop("sim_last", 8'hAA);
        check("sim_empty", {31'd0, empty}, 32'd1);

        // Short low glitch.
        snap_f = ferr_cnt;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (40) tick();
        $display("[TB] glitch 4 cycles");
        check("glitch_empty", {31'd0, empty}, 32'd1);
        check("glitch_noferr", ferr_cnt - snap_f, 32'd0);

        // Reset mid data bit 3, with a byte already buffered.
        send(8'h5A, 1'b1, 0);
        tick();
        check("prerst_nonempty", {31'd0, empty}, 32'd0);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (CPB) tick();
        end
        rx = 1'b1;
        repeat (CPB / 2) tick();
        rst_n = 1'b0;
        #2;
        $display("[TB] async reset mid-frame");
        check("mrst_empty", {31'd0, empty}, 32'd1);
        check("mrst_full",  {31'd0, full},  32'd0);
        check("mrst_data",  {24'd0, data},  32'd0);
        check("mrst_ferr",  {31'd0, ferr},  32'd0);
        check("mrst_ovr",   {31'd0, ovr},   32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        snap_f = ferr_cnt;
        send(8'hC3, 1'b1, 0);
        tick();
        $display("[TB] post-reset 0xC3");
        check("postrst_noferr", ferr_cnt - snap_f, 32'd0);
        pop("postrst", 8'hC3);
        check("postrst_empty", {31'd0, empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
